// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared audio types for the codec-side buffers.
//   sample_t   : one 16-bit PCM sample
//   stereo_t   : packed L/R pair, [AUDIO_CH_L]=left, [AUDIO_CH_R]=right
//   tx_state_e : playback buffer state (pre-fill / running)
// -----------------------------------------------------------------------------
package audio_pkg;

   typedef logic [15:0] sample_t;
   typedef sample_t [1:0] stereo_t;

   localparam int AUDIO_CH_L = 0;
   localparam int AUDIO_CH_R = 1;

   localparam logic [15:0] AUDIO_CNT_MAX = 16'hFFFF;

   typedef enum logic [0:0] {
      TX_FILL = 1'b0,
      TX_RUN  = 1'b1
   } tx_state_e;

endpackage

// File: rtl/fifo_ring.sv
// -----------------------------------------------------------------------------
// fifo_ring
// Generic single-clock ring buffer: storage array, write/read pointers and a
// level counter one bit wider than the pointers so full and empty differ.
// Head data is presented combinationally from the read pointer.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-low reset
//   i_push, i_wr_dat  write request and data (ignored when full)
//   i_pop             read request (ignored when empty)
//   o_rd_dat          data at the head of the ring
//   o_level           registered number of stored entries
//   o_level_nxt       level after the current cycle's push/pop
// -----------------------------------------------------------------------------
module fifo_ring #(
   parameter int p_width = 32,
   parameter int p_depth = 64
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic [p_width-1:0]         i_wr_dat,
   input  logic                       i_pop,
   output logic [p_width-1:0]         o_rd_dat,
   output logic [$clog2(p_depth):0]   o_level,
   output logic [$clog2(p_depth):0]   o_level_nxt
);

   localparam int c_aw = $clog2(p_depth);
   localparam logic [c_aw:0] c_full = (c_aw+1)'(p_depth);

   logic [p_width-1:0] mem_q [p_depth];
   logic [c_aw-1:0]    wr_ptr_q, wr_ptr_d;
   logic [c_aw-1:0]    rd_ptr_q, rd_ptr_d;
   logic [c_aw:0]      level_q, level_d;
   logic               push_ok, pop_ok;

   assign push_ok = i_push && (level_q != c_full);
   assign pop_ok  = i_pop  && (level_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      // pointers wrap naturally at p_depth (power of two)
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // storage needs no reset: an empty ring never exposes its contents
   always_ff @(posedge i_clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= i_wr_dat;
   end

   assign o_rd_dat    = mem_q[rd_ptr_q];
   assign o_level     = level_q;
   assign o_level_nxt = level_d;

endmodule

// File: rtl/audio_tx_fifo.sv
// -----------------------------------------------------------------------------
// audio_tx_fifo
// Stereo playback buffer in front of the WM8731 codec driver. Pre-fills to
// p_threshold pairs, then hands one pair per driver frame-load strobe. On
// underrun the output is muted to 0/0 and the buffer returns to pre-fill.
//
// Optional build macro: AUDIO_TX_FIFO_STATS_EN adds o_underrun_cnt, a 16-bit
// saturating count of underrun events.
//
// Ports:
//   i_clk, i_rst      system clock, asynchronous active-low reset
//   i_wr_dat          write pair, [0]=left [1]=right
//   i_wr_val/o_wr_rdy write handshake; o_wr_rdy registered, = !full
//   o_dat             pair held for the driver, [0]=left [1]=right
//   i_ack             driver frame-load strobe (1-cycle pulse)
//   o_level           pairs stored
//   o_run             1 = RUN, 0 = FILL
//   o_underrun        sticky underrun flag
//   o_underrun_cnt    underrun count (AUDIO_TX_FIFO_STATS_EN only)
//
// state   | meaning
// TX_FILL | pre-filling; strobes pop nothing and mute the output
// TX_RUN  | playing; each strobe pops the head, empty strobe = underrun
// -----------------------------------------------------------------------------
module audio_tx_fifo
   import audio_pkg::*;
#(
   parameter int p_depth     = 64,
   parameter int p_threshold = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [1:0][15:0]          i_wr_dat,
   input  logic                      i_wr_val,
   output logic                      o_wr_rdy,
   output logic [1:0][15:0]          o_dat,
   input  logic                      i_ack,
   output logic [$clog2(p_depth):0]  o_level,
   output logic                      o_run,
   output logic                      o_underrun
`ifdef AUDIO_TX_FIFO_STATS_EN
   ,
   output logic [15:0]               o_underrun_cnt
`endif
);

   localparam int c_aw = $clog2(p_depth);
   localparam logic [c_aw:0] c_full = (c_aw+1)'(p_depth);
   localparam logic [c_aw:0] c_thr  = (c_aw+1)'(p_threshold);

   tx_state_e     state_q, state_d;
   stereo_t       dat_q, dat_d;
   logic          wr_rdy_q, wr_rdy_d;
   logic          underrun_q, underrun_d;

   stereo_t       head;
   logic [c_aw:0] level;
   logic [c_aw:0] level_nxt;
   logic          push, pop, underrun_evt, fifo_empty, is_run;

   assign is_run      = (state_q == TX_RUN);
   assign fifo_empty  = (level == '0);
   assign push        = i_wr_val && wr_rdy_q;
   assign pop         = is_run && i_ack && !fifo_empty;
   // a push landing in the same cycle does not rescue an empty strobe
   assign underrun_evt = is_run && i_ack && fifo_empty;

   fifo_ring #(
      .p_width (32),
      .p_depth (p_depth)
   ) u_ring (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (push),
      .i_wr_dat    (i_wr_dat),
      .i_pop       (pop),
      .o_rd_dat    (head),
      .o_level     (level),
      .o_level_nxt (level_nxt)
   );

   always_comb begin
      state_d    = state_q;
      dat_d      = dat_q;
      underrun_d = underrun_q;
      // ready follows the level after this cycle, so a pop while full only
      // re-opens the write port on the following cycle
      wr_rdy_d   = (level_nxt != c_full);

      if (i_ack) begin
         dat_d = pop ? head : '0;
      end

      if (underrun_evt) begin
         state_d    = TX_FILL;
         underrun_d = 1'b1;
      end else if ((state_q == TX_FILL) && (level_nxt >= c_thr)) begin
         state_d = TX_RUN;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q    <= TX_FILL;
         dat_q      <= '0;
         wr_rdy_q   <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         dat_q      <= dat_d;
         wr_rdy_q   <= wr_rdy_d;
         underrun_q <= underrun_d;
      end
   end

`ifdef AUDIO_TX_FIFO_STATS_EN
   logic [15:0] und_cnt_q, und_cnt_d;

   always_comb begin
      und_cnt_d = und_cnt_q;
      if (underrun_evt && (und_cnt_q != AUDIO_CNT_MAX)) und_cnt_d = und_cnt_q + 16'd1;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) und_cnt_q <= '0;
      else        und_cnt_q <= und_cnt_d;
   end

   assign o_underrun_cnt = und_cnt_q;
`endif

   assign o_wr_rdy   = wr_rdy_q;
   assign o_dat      = dat_q;
   assign o_level    = level;
   assign o_run      = is_run;
   assign o_underrun = underrun_q;

endmodule

// File: tb/tb_audio_tx_fifo.sv
module tb_audio_tx_fifo;

   localparam int DEPTH = 64;
   localparam int THR   = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [1:0][15:0]  wr_dat = '0;
   logic              wr_val = 1'b0;
   logic              ack = 1'b0;
   logic              wr_rdy;
   logic [1:0][15:0]  dat;
   logic [LW-1:0]     level;
   logic              run;
   logic              underrun;
`ifdef AUDIO_TX_FIFO_STATS_EN
   logic [15:0]       underrun_cnt;
`endif

   always #5 clk = ~clk;

   audio_tx_fifo #(.p_depth(DEPTH), .p_threshold(THR)) dut (
      .i_clk      (clk),
      .i_rst      (rst_n),
      .i_wr_dat   (wr_dat),
      .i_wr_val   (wr_val),
      .o_wr_rdy   (wr_rdy),
      .o_dat      (dat),
      .i_ack      (ack),
      .o_level    (level),
      .o_run      (run),
      .o_underrun (underrun)
`ifdef AUDIO_TX_FIFO_STATS_EN
      ,
      .o_underrun_cnt (underrun_cnt)
`endif
   );

`ifdef AUDIO_TX_FIFO_STATS_EN
   // threshold-1 instance so underruns can be produced every three cycles
   logic              v2 = 1'b0;
   logic              a2 = 1'b0;
   logic [1:0][15:0]  d2 = '0;
   logic              rdy2, run2, und2;
   logic [1:0][15:0]  dat2;
   logic [LW-1:0]     lvl2;
   logic [15:0]       cnt2;

   audio_tx_fifo #(.p_depth(DEPTH), .p_threshold(1)) dut2 (
      .i_clk          (clk),
      .i_rst          (rst_n),
      .i_wr_dat       (d2),
      .i_wr_val       (v2),
      .o_wr_rdy       (rdy2),
      .o_dat          (dat2),
      .i_ack          (a2),
      .o_level        (lvl2),
      .o_run          (run2),
      .o_underrun     (und2),
      .o_underrun_cnt (cnt2)
   );
`endif

   int n_vec = 0;
   int n_err = 0;

   // reference model + scoreboard
   logic [1:0][15:0] sb_q [$];
   int               m_level;
   logic             m_run, m_und, m_rdy;
   logic [1:0][15:0] m_dat;
   logic [15:0]      m_cnt;

   task automatic model_reset();
      sb_q.delete();
      m_level = 0; m_run = 0; m_und = 0; m_rdy = 0; m_dat = '0; m_cnt = '0;
   endtask

   // drive one cycle of stimulus at posedge+1, advance the model, return at next posedge+1
   task automatic drive_cycle(input logic val, input logic [1:0][15:0] d, input logic a);
      logic push, pop, und;
      int   lvl_n;
      wr_val = val; wr_dat = d; ack = a;
      push = val & m_rdy;
      pop  = a & m_run & (m_level > 0);
      und  = a & m_run & (m_level == 0);
      if (push) sb_q.push_back(d);
      if (pop) m_dat = sb_q.pop_front();
      else if (a) m_dat = '0;
      lvl_n = m_level + int'(push) - int'(pop);
      if (und) m_run = 1'b0;
      else if (!m_run && lvl_n >= THR) m_run = 1'b1;
      if (und) begin
         m_und = 1'b1;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      m_rdy   = (lvl_n != DEPTH);
      m_level = lvl_n;
      @(posedge clk); #1;
      wr_val = 1'b0; ack = 1'b0;
   endtask

   function automatic logic [1:0][15:0] mk_pair(input logic [15:0] n);
      logic [1:0][15:0] p;
      p[0] = n;
      p[1] = ~n;
      return p;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_vec++; if (dat !== '0)      begin n_err++; $display("FAIL reset_dat: got %h want 0", dat); end
      n_vec++; if (level !== '0)    begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
      n_vec++; if (run !== 1'b0)    begin n_err++; $display("FAIL reset_run: got %b want 0", run); end
      n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b want 0", underrun); end
      @(posedge clk); #1;
      n_vec++; if (wr_rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy_held: got %b want 0", wr_rdy); end
      rst_n = 1'b1;
      model_reset();
      drive_cycle(1'b0, '0, 1'b0);
      n_vec++; if (wr_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy_release: got %b want 1", wr_rdy); end
   endtask

   task automatic test_fill();
      for (int n = 0; n < 16; n++) begin
         drive_cycle(1'b1, mk_pair(16'(n)), 1'b0);
         n_vec++; if (level !== LW'(m_level)) begin n_err++; $display("FAIL fill_level[%0d]: got %0d want %0d", n, level, m_level); end
         n_vec++; if (run !== m_run) begin n_err++; $display("FAIL fill_run[%0d]: got %b want %b", n, run, m_run); end
         n_vec++; if (dat !== '0) begin n_err++; $display("FAIL fill_dat[%0d]: got %h want 0", n, dat); end
      end
      n_vec++; if (run !== 1'b1) begin n_err++; $display("FAIL fill_run_at_thr: got %b want 1", run); end
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, '0, 1'b0);
         n_vec++; if (dat !== '0) begin n_err++; $display("FAIL fill_dat_idle: got %h want 0", dat); end
      end
      drive_cycle(1'b0, '0, 1'b1);
      n_vec++; if (dat !== {16'hFFFF, 16'h0000}) begin n_err++; $display("FAIL first_ack_dat: got %h want ffff0000", dat); end
   endtask

   task automatic test_drain_underrun();
      logic [1:0][15:0] hold;
      for (int n = 1; n < 16; n++) begin
         drive_cycle(1'b0, '0, 1'b1);
         n_vec++; if (dat !== m_dat) begin n_err++; $display("FAIL drain_dat[%0d]: got %h want %h", n, dat, m_dat); end
         hold = m_dat;
         drive_cycle(1'b0, '0, 1'b0);
         n_vec++; if (dat !== hold) begin n_err++; $display("FAIL drain_hold[%0d]: got %h want %h", n, dat, hold); end
      end
      drive_cycle(1'b0, '0, 1'b1);
      n_vec++; if (dat !== '0)      begin n_err++; $display("FAIL underrun_dat: got %h want 0", dat); end
      n_vec++; if (underrun !== 1'b1) begin n_err++; $display("FAIL underrun_flag: got %b want 1", underrun); end
      n_vec++; if (run !== 1'b0)    begin n_err++; $display("FAIL underrun_run: got %b want 0", run); end
`ifdef AUDIO_TX_FIFO_STATS_EN
      n_vec++; if (underrun_cnt !== 16'd1) begin n_err++; $display("FAIL underrun_cnt: got %0d want 1", underrun_cnt); end
`endif
   endtask

   task automatic test_full();
      logic [1:0][15:0] extra;
      extra = mk_pair(16'h01AA);
      for (int i = 0; i < DEPTH; i++) begin
         drive_cycle(1'b1, mk_pair(16'(16'h0100 + i)), 1'b0);
         n_vec++; if (level !== LW'(m_level)) begin n_err++; $display("FAIL full_level[%0d]: got %0d want %0d", i, level, m_level); end
      end
      n_vec++; if (level !== LW'(DEPTH)) begin n_err++; $display("FAIL full_level64: got %0d want %0d", level, DEPTH); end
      n_vec++; if (wr_rdy !== 1'b0) begin n_err++; $display("FAIL full_rdy: got %b want 0", wr_rdy); end
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b1, extra, 1'b0);
         n_vec++; if (level !== LW'(DEPTH)) begin n_err++; $display("FAIL full_hold_level: got %0d want %0d", level, DEPTH); end
      end
      drive_cycle(1'b1, extra, 1'b1);
      n_vec++; if (level !== LW'(DEPTH - 1)) begin n_err++; $display("FAIL full_pop_level: got %0d want %0d", level, DEPTH - 1); end
      n_vec++; if (wr_rdy !== 1'b1) begin n_err++; $display("FAIL full_pop_rdy: got %b want 1", wr_rdy); end
      n_vec++; if (dat !== m_dat) begin n_err++; $display("FAIL full_pop_dat: got %h want %h", dat, m_dat); end
      drive_cycle(1'b1, extra, 1'b0);
      n_vec++; if (level !== LW'(DEPTH)) begin n_err++; $display("FAIL full_accept_level: got %0d want %0d", level, DEPTH); end
      for (int i = 0; i < DEPTH; i++) begin
         drive_cycle(1'b0, '0, 1'b1);
         n_vec++; if (dat !== m_dat) begin n_err++; $display("FAIL full_drain_dat[%0d]: got %h want %h", i, dat, m_dat); end
      end
      n_vec++; if (dat !== extra) begin n_err++; $display("FAIL full_last_is_held: got %h want %h", dat, extra); end
      n_vec++; if (level !== '0) begin n_err++; $display("FAIL full_drained_level: got %0d want 0", level); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) drive_cycle(1'b1, mk_pair(16'(16'h0200 + i)), 1'b0);
      n_vec++; if (level !== LW'(5)) begin n_err++; $display("FAIL b2b_level5: got %0d want 5", level); end
      for (int i = 0; i < 3 * DEPTH; i++) begin
         drive_cycle(1'b1, mk_pair(16'(16'h0300 + i)), 1'b1);
         n_vec++; if (level !== LW'(5)) begin n_err++; $display("FAIL b2b_level[%0d]: got %0d want 5", i, level); end
         n_vec++; if (dat !== m_dat) begin n_err++; $display("FAIL b2b_dat[%0d]: got %h want %h", i, dat, m_dat); end
      end
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b0, '0, 1'b1);
         n_vec++; if (dat !== m_dat) begin n_err++; $display("FAIL b2b_tail[%0d]: got %h want %h", i, dat, m_dat); end
      end
      n_vec++; if (run !== 1'b1) begin n_err++; $display("FAIL b2b_run: got %b want 1", run); end
   endtask

   task automatic test_empty_push_ack();
      logic [1:0][15:0] px;
      px = mk_pair(16'h0400);
      drive_cycle(1'b1, px, 1'b1);
      n_vec++; if (dat !== '0)     begin n_err++; $display("FAIL epa_dat: got %h want 0", dat); end
      n_vec++; if (run !== 1'b0)   begin n_err++; $display("FAIL epa_run: got %b want 0", run); end
      n_vec++; if (level !== LW'(1)) begin n_err++; $display("FAIL epa_level: got %0d want 1", level); end
      for (int i = 1; i < 16; i++) drive_cycle(1'b1, mk_pair(16'(16'h0400 + i)), 1'b0);
      n_vec++; if (run !== m_run) begin n_err++; $display("FAIL epa_refill_run: got %b want %b", run, m_run); end
      drive_cycle(1'b0, '0, 1'b1);
      n_vec++; if (dat !== px) begin n_err++; $display("FAIL epa_stored: got %h want %h", dat, px); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 15; i++) drive_cycle(1'b1, mk_pair(16'(16'h0500 + i)), 1'b0);
      drive_cycle(1'b0, '0, 1'b1);
      drive_cycle(1'b1, mk_pair(16'h05FF), 1'b0);
      n_vec++; if (level !== LW'(30)) begin n_err++; $display("FAIL mid_level30: got %0d want 30", level); end
      #3;
      rst_n = 1'b0;
      #1;
      n_vec++; if (dat !== '0)    begin n_err++; $display("FAIL mid_rst_dat: got %h want 0", dat); end
      n_vec++; if (level !== '0)  begin n_err++; $display("FAIL mid_rst_level: got %0d want 0", level); end
      n_vec++; if (run !== 1'b0)  begin n_err++; $display("FAIL mid_rst_run: got %b want 0", run); end
      n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL mid_rst_underrun: got %b want 0", underrun); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      drive_cycle(1'b0, '0, 1'b0);
      for (int i = 0; i < 16; i++) drive_cycle(1'b1, mk_pair(16'(16'h0700 + i)), 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, '0, 1'b1);
         n_vec++; if (dat !== m_dat) begin n_err++; $display("FAIL mid_new_dat[%0d]: got %h want %h", i, dat, m_dat); end
      end
   endtask

`ifdef AUDIO_TX_FIFO_STATS_EN
   task automatic test_stats_saturate();
      for (int i = 0; i < 70000; i++) begin
         v2 = 1'b1; d2 = mk_pair(16'(i));
         @(posedge clk); #1;
         v2 = 1'b0; a2 = 1'b1;
         @(posedge clk); #1;
         @(posedge clk); #1;
         a2 = 1'b0;
         if (i == 0) begin
            n_vec++; if (cnt2 !== 16'd1) begin n_err++; $display("FAIL stats_first: got %0d want 1", cnt2); end
            n_vec++; if (run2 !== 1'b0)  begin n_err++; $display("FAIL stats_run: got %b want 0", run2); end
         end
         if (i == 65533) begin
            n_vec++; if (cnt2 !== 16'hFFFE) begin n_err++; $display("FAIL stats_fffe: got %h want fffe", cnt2); end
         end
         if (i == 65534) begin
            n_vec++; if (cnt2 !== 16'hFFFF) begin n_err++; $display("FAIL stats_ffff: got %h want ffff", cnt2); end
         end
      end
      n_vec++; if (cnt2 !== 16'hFFFF) begin n_err++; $display("FAIL stats_saturate: got %h want ffff", cnt2); end
      n_vec++; if (und2 !== 1'b1) begin n_err++; $display("FAIL stats_flag: got %b want 1", und2); end
   endtask
`endif

   initial begin
      model_reset();
      #2;
      test_reset();
      test_fill();
      test_drain_underrun();
      test_full();
      test_back_to_back();
      test_empty_push_ack();
      test_reset_mid();
`ifdef AUDIO_TX_FIFO_STATS_EN
      test_stats_saturate();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
